// File: rtl/atmega_uart_pkg.sv
// Shared definitions for the atmega_uart register-bus sequencer.
// Holds the UCSRA/UCSRB/UCSRC bit positions of the UART and the state
// encoding of the controller FSM. No ports; imported by the controller.
package atmega_uart_pkg;

  // UCSRA status bits
  localparam int UCSRA_RXC  = 7;
  localparam int UCSRA_TXC  = 6;
  localparam int UCSRA_UDRE = 5;
  localparam int UCSRA_FE   = 4;
  localparam int UCSRA_DOR  = 3;
  localparam int UCSRA_UPE  = 2;
  localparam int UCSRA_U2X  = 1;
  localparam int UCSRA_MPCM = 0;

  // UCSRB control bits
  localparam int UCSRB_RXCIE = 7;
  localparam int UCSRB_TXCIE = 6;
  localparam int UCSRB_UDRIE = 5;
  localparam int UCSRB_RXEN  = 4;
  localparam int UCSRB_TXEN  = 3;
  localparam int UCSRB_UCSZ2 = 2;
  localparam int UCSRB_RXB8  = 1;
  localparam int UCSRB_TXB8  = 0;

  // UCSRC frame-format bits
  localparam int UCSRC_UMSEL = 6;
  localparam int UCSRC_UPM1  = 5;
  localparam int UCSRC_UPM0  = 4;
  localparam int UCSRC_USBS  = 3;
  localparam int UCSRC_UCSZ1 = 2;
  localparam int UCSRC_UCSZ0 = 1;
  localparam int UCSRC_UCPOL = 0;

  // Controller FSM: four configuration writes, then the service loop
  typedef enum logic [2:0] {
    CFG_L  = 3'd0,
    CFG_H  = 3'd1,
    CFG_C  = 3'd2,
    CFG_B  = 3'd3,
    POLL   = 3'd4,
    RD_UDR = 3'd5,
    WR_UDR = 3'd6,
    GAP    = 3'd7
  } ctrl_state_e;

endpackage

// File: rtl/atmega_uart_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches the request vector starting one position after the last grant
// and returns the first active requester as a one-hot grant plus index.
// The pointer itself lives in the parent.
//   req_i   : request vector
//   last_i  : index of the previous grant
//   en_i    : arbitration enable; grant is all-zero when low
//   grant_o : one-hot grant
//   idx_o   : index of the granted requester
//   valid_o : a grant was issued
module rr_arbiter #(
  parameter int N = 4,
  localparam int IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] last_i,
  input  logic            en_i,
  output logic [N-1:0]    grant_o,
  output logic [IdxW-1:0] idx_o,
  output logic            valid_o
);

  int cand;

  // Offsets 1..N cover every requester once, with the last grantee
  // examined last so it cannot starve the others.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = 0;
    for (int i = 1; i <= N; i++) begin
      cand = (int'(last_i) + i) % N;
      if (en_i && !valid_o && req_i[cand[IdxW-1:0]]) begin
        valid_o                = 1'b1;
        idx_o                  = cand[IdxW-1:0];
        grant_o[cand[IdxW-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/atmega_uart_ctrl.sv
// Bus-master sequencer between NUM_REQ byte-stream clients and one
// atmega_uart. After reset it writes UBRRL, UBRRH, UCSRC, UCSRB, then
// polls UCSRA, moving received bytes into a one-deep holding register and
// writing round-robin granted client bytes to UDR.
//   clk_i, rst_i      : clock, synchronous active-low reset
//   cfg_req_i         : pulse to rerun the configuration sequence
//   tx_valid_i/data_i : per-requester byte stream, tx_ready_o one-hot accept
//   rx_valid_o/data_o : held received byte, rx_ferr_o its framing error
//   rx_ready_i        : consumer accepts the held byte
//   uart_*            : registered UART register bus (uart_dat_i combinational)
//   cfg_done_o        : configuration complete
//   busy_o            : FSM is not in POLL
module atmega_uart_ctrl
  import atmega_uart_pkg::*;
#(
  parameter int                           BUS_ADDR_DATA_LEN = 8,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] UDR_ADDR          = 'hc1,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] UCSRA_ADDR        = 'hc8,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] UCSRB_ADDR        = 'hc9,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] UCSRC_ADDR        = 'hca,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] UBRRL_ADDR        = 'hcc,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] UBRRH_ADDR        = 'hcd,
  parameter int                           NUM_REQ           = 4,
  parameter logic [11:0]                  UBRR_INIT         = 12'd103,
  parameter logic [7:0]                   UCSRC_INIT        = 8'h06,
  parameter logic [7:0]                   UCSRB_INIT        = 8'h18
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         cfg_req_i,
  input  logic [NUM_REQ-1:0]           tx_valid_i,
  input  logic [8*NUM_REQ-1:0]         tx_data_i,
  output logic [NUM_REQ-1:0]           tx_ready_o,
  output logic                         rx_valid_o,
  output logic [7:0]                   rx_data_o,
  output logic                         rx_ferr_o,
  input  logic                         rx_ready_i,
  output logic [BUS_ADDR_DATA_LEN-1:0] uart_addr_o,
  output logic                         uart_wr_o,
  output logic                         uart_rd_o,
  output logic [7:0]                   uart_dat_o,
  input  logic [7:0]                   uart_dat_i,
  output logic                         cfg_done_o,
  output logic                         busy_o
);

  localparam int IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  ctrl_state_e state_q, state_d;

  logic [IdxW-1:0]              rr_q, rr_d;
  logic                         cfgPend_q, cfgPend_d;
  logic                         feLatch_q, feLatch_d;
  logic                         rxValid_q, rxValid_d;
  logic [7:0]                   rxData_q, rxData_d;
  logic                         rxFerr_q, rxFerr_d;
  logic                         cfgDone_q, cfgDone_d;
  logic                         busy_q, busy_d;
  logic                         busWr_q, busWr_d;
  logic                         busRd_q, busRd_d;
  logic [BUS_ADDR_DATA_LEN-1:0] busAddr_q, busAddr_d;
  logic [7:0]                   busDat_q, busDat_d;
  logic [NUM_REQ-1:0]           txReady_q, txReady_d;

  logic               arbEn;
  logic [NUM_REQ-1:0] arbGrant;
  logic [IdxW-1:0]    arbIdx;
  logic               arbValid;
  logic [7:0]         txByte;
  logic               inCfg;
  logic               rxCanRead;
  logic               txCanWrite;

  assign arbEn = (state_q == POLL);

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req_i   (tx_valid_i),
    .last_i  (rr_q),
    .en_i    (arbEn),
    .grant_o (arbGrant),
    .idx_o   (arbIdx),
    .valid_o (arbValid)
  );

  // One-hot mux of the granted requester's byte
  always_comb begin
    txByte = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (arbGrant[k]) txByte = tx_data_i[8*k +: 8];
    end
  end

  // uart_dat_i only carries UCSRA while in POLL, so these are qualified there
  assign inCfg      = (state_q == CFG_L) || (state_q == CFG_H) ||
                      (state_q == CFG_C) || (state_q == CFG_B);
  assign rxCanRead  = uart_dat_i[UCSRA_RXC] && (!rxValid_q || rx_ready_i);
  assign txCanWrite = uart_dat_i[UCSRA_UDRE] && arbValid;

  // Next-state logic. CFG_L waits until its write is actually on the bus:
  // after reset the bus is idle in CFG_L, whereas entry from POLL issues
  // the write on the same edge.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CFG_L:  if (busWr_q) state_d = CFG_H;
      CFG_H:  state_d = CFG_C;
      CFG_C:  state_d = CFG_B;
      CFG_B:  state_d = GAP;
      POLL: begin
        if (cfgPend_q)       state_d = CFG_L;
        else if (rxCanRead)  state_d = RD_UDR;
        else if (txCanWrite) state_d = WR_UDR;
      end
      RD_UDR: state_d = GAP;
      WR_UDR: state_d = GAP;
      GAP:    state_d = POLL;
      default: state_d = CFG_L;
    endcase
  end

  // Bus outputs are registered from the next state so each operation is
  // on the bus during the cycle the FSM sits in the matching state.
  always_comb begin
    busWr_d   = 1'b0;
    busRd_d   = 1'b0;
    busAddr_d = '0;
    busDat_d  = '0;
    txReady_d = '0;
    unique case (state_d)
      CFG_L: begin
        busWr_d   = 1'b1;
        busAddr_d = UBRRL_ADDR;
        busDat_d  = UBRR_INIT[7:0];
      end
      CFG_H: begin
        busWr_d   = 1'b1;
        busAddr_d = UBRRH_ADDR;
        busDat_d  = {4'h0, UBRR_INIT[11:8]};
      end
      CFG_C: begin
        busWr_d   = 1'b1;
        busAddr_d = UCSRC_ADDR;
        busDat_d  = UCSRC_INIT;
      end
      CFG_B: begin
        busWr_d   = 1'b1;
        busAddr_d = UCSRB_ADDR;
        busDat_d  = UCSRB_INIT;
      end
      POLL: begin
        busRd_d   = 1'b1;
        busAddr_d = UCSRA_ADDR;
      end
      RD_UDR: begin
        busRd_d   = 1'b1;
        busAddr_d = UDR_ADDR;
      end
      // WR_UDR is only reachable from POLL, where the arbiter is enabled
      WR_UDR: begin
        busWr_d   = 1'b1;
        busAddr_d = UDR_ADDR;
        busDat_d  = txByte;
        txReady_d = arbGrant;
      end
      default: ;
    endcase
  end

  // Bookkeeping: rr pointer, cfg request latch, FE latch, rx holding
  // register and status flags.
  always_comb begin
    rr_d      = rr_q;
    feLatch_d = feLatch_q;
    rxValid_d = rxValid_q;
    rxData_d  = rxData_q;
    rxFerr_d  = rxFerr_q;
    cfgDone_d = cfgDone_q;
    cfgPend_d = cfgPend_q;

    if (state_q == POLL && state_d == WR_UDR) rr_d = arbIdx;
    if (state_q == POLL && state_d == RD_UDR) feLatch_d = uart_dat_i[UCSRA_FE];

    // A reload in RD_UDR wins over a simultaneous consume
    if (state_q == RD_UDR) begin
      rxValid_d = 1'b1;
      rxData_d  = uart_dat_i;
      rxFerr_d  = feLatch_q;
    end else if (rxValid_q && rx_ready_i) begin
      rxValid_d = 1'b0;
    end

    if (state_d == POLL)       cfgDone_d = 1'b1;
    else if (state_d == CFG_L) cfgDone_d = 1'b0;

    // Requests arriving while configuring are dropped; taking one clears it
    if (state_q == POLL && cfgPend_q) cfgPend_d = 1'b0;
    else if (cfg_req_i && !inCfg)     cfgPend_d = 1'b1;
  end

  assign busy_d = (state_d != POLL);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= CFG_L;
      rr_q      <= IdxW'(NUM_REQ - 1);
      cfgPend_q <= 1'b0;
      feLatch_q <= 1'b0;
      rxValid_q <= 1'b0;
      rxData_q  <= '0;
      rxFerr_q  <= 1'b0;
      cfgDone_q <= 1'b0;
      busy_q    <= 1'b0;
      busWr_q   <= 1'b0;
      busRd_q   <= 1'b0;
      busAddr_q <= '0;
      busDat_q  <= '0;
      txReady_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      cfgPend_q <= cfgPend_d;
      feLatch_q <= feLatch_d;
      rxValid_q <= rxValid_d;
      rxData_q  <= rxData_d;
      rxFerr_q  <= rxFerr_d;
      cfgDone_q <= cfgDone_d;
      busy_q    <= busy_d;
      busWr_q   <= busWr_d;
      busRd_q   <= busRd_d;
      busAddr_q <= busAddr_d;
      busDat_q  <= busDat_d;
      txReady_q <= txReady_d;
    end
  end

  assign uart_wr_o   = busWr_q;
  assign uart_rd_o   = busRd_q;
  assign uart_addr_o = busAddr_q;
  assign uart_dat_o  = busDat_q;
  assign tx_ready_o  = txReady_q;
  assign rx_valid_o  = rxValid_q;
  assign rx_data_o   = rxData_q;
  assign rx_ferr_o   = rxFerr_q;
  assign cfg_done_o  = cfgDone_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_atmega_uart_ctrl.sv
// Self-checking bench for atmega_uart_ctrl: a small UART register stub
// answers reads, and every non-poll bus operation is compared in order
// against a queue of expected operations.
module tb_atmega_uart_ctrl;

  localparam logic [7:0] A_UDR   = 8'hc1;
  localparam logic [7:0] A_UCSRA = 8'hc8;
  localparam logic [7:0] A_UCSRB = 8'hc9;
  localparam logic [7:0] A_UCSRC = 8'hca;
  localparam logic [7:0] A_UBRRL = 8'hcc;
  localparam logic [7:0] A_UBRRH = 8'hcd;

  typedef struct packed {
    logic       wr;
    logic       rd;
    logic [7:0] addr;
    logic [7:0] dat;
    logic [3:0] ready;
  } busOp_t;

  logic        clk;
  logic        rstN;
  logic        cfgReq;
  logic [3:0]  txValid;
  logic [31:0] txData;
  logic [3:0]  txReady;
  logic        rxValid;
  logic [7:0]  rxData;
  logic        rxFerr;
  logic        rxReady;
  logic [7:0]  uartAddr;
  logic        uartWr;
  logic        uartRd;
  logic [7:0]  uartDatOut;
  logic [7:0]  uartDatIn;
  logic        cfgDone;
  logic        busy;

  logic        stubUdre;
  logic        stubFe;
  logic [7:0]  stubRxByte;
  logic        stubRxc;
  int          rxSetCount;
  int          rxReadCount;

  busOp_t      expQ[$];
  int          wrCycles[$];
  int          cycleCount;
  int          compared;
  int          mismatched;

  atmega_uart_ctrl dut (
    .clk_i       (clk),
    .rst_i       (rstN),
    .cfg_req_i   (cfgReq),
    .tx_valid_i  (txValid),
    .tx_data_i   (txData),
    .tx_ready_o  (txReady),
    .rx_valid_o  (rxValid),
    .rx_data_o   (rxData),
    .rx_ferr_o   (rxFerr),
    .rx_ready_i  (rxReady),
    .uart_addr_o (uartAddr),
    .uart_wr_o   (uartWr),
    .uart_rd_o   (uartRd),
    .uart_dat_o  (uartDatOut),
    .uart_dat_i  (uartDatIn),
    .cfg_done_o  (cfgDone),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // UART stub: RXC stays up until the controller reads UDR
  assign stubRxc   = (rxSetCount != rxReadCount);
  assign uartDatIn = !uartRd ? 8'h00 :
                     (uartAddr == A_UCSRA) ? {stubRxc, 1'b0, stubUdre, stubFe, 4'h0} :
                     (uartAddr == A_UDR)   ? stubRxByte : 8'h00;

  function automatic busOp_t mkOp(input logic wr, input logic [7:0] addr,
                                  input logic [7:0] dat, input logic [3:0] ready);
    busOp_t op;
    op.wr    = wr;
    op.rd    = ~wr;
    op.addr  = addr;
    op.dat   = dat;
    op.ready = ready;
    return op;
  endfunction

  task automatic push_cfg();
    expQ.push_back(mkOp(1'b1, A_UBRRL, 8'h67, 4'h0));
    expQ.push_back(mkOp(1'b1, A_UBRRH, 8'h00, 4'h0));
    expQ.push_back(mkOp(1'b1, A_UCSRC, 8'h06, 4'h0));
    expQ.push_back(mkOp(1'b1, A_UCSRB, 8'h18, 4'h0));
  endtask

  // Scoreboard side: every bus op except the UCSRA poll is popped and compared
  task automatic run_bus_monitor();
    busOp_t seen;
    busOp_t exp;
    forever begin
      @(negedge clk);
      cycleCount++;
      if (uartWr && uartRd) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL bus_exclusive: wr=%b rd=%b, required not both", uartWr, uartRd);
      end
      if ((uartWr || uartRd) && !(uartRd && !uartWr && uartAddr == A_UCSRA)) begin
        seen.wr    = uartWr;
        seen.rd    = uartRd;
        seen.addr  = uartAddr;
        seen.dat   = uartDatOut;
        seen.ready = txReady;
        if (uartRd && uartAddr == A_UDR) rxReadCount++;
        if (uartWr && uartAddr == A_UDR) wrCycles.push_back(cycleCount);
        compared++;
        if (expQ.size() == 0) begin
          mismatched++;
          $display("[TB] FAIL bus_op_unexpected: got wr=%b rd=%b addr=%h dat=%h ready=%b, required none",
                   seen.wr, seen.rd, seen.addr, seen.dat, seen.ready);
        end else begin
          exp = expQ.pop_front();
          if (seen !== exp) begin
            mismatched++;
            $display("[TB] FAIL bus_op: got wr=%b rd=%b addr=%h dat=%h ready=%b, required wr=%b rd=%b addr=%h dat=%h ready=%b",
                     seen.wr, seen.rd, seen.addr, seen.dat, seen.ready,
                     exp.wr, exp.rd, exp.addr, exp.dat, exp.ready);
          end
        end
      end else if (txReady != 4'h0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL ready_without_write: got ready=%b, required 0000", txReady);
      end
    end
  endtask

  // Requester model: drops valid the cycle after its ready strobe
  task automatic serve_tx(input int maxCycles, output bit done);
    logic [3:0] clearNext;
    clearNext = 4'h0;
    done      = 1'b0;
    for (int c = 0; c < maxCycles; c++) begin
      @(negedge clk);
      txValid   = txValid & ~clearNext;
      clearNext = txReady & txValid;
      if (txValid == 4'h0 && clearNext == 4'h0 && expQ.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    rstN = 1'b0;
    repeat (3) @(negedge clk);
    compared++;
    if ({uartWr, uartRd, uartAddr, uartDatOut, txReady, rxValid, rxData, rxFerr, cfgDone, busy} !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs: got wr=%b rd=%b addr=%h dat=%h ready=%b rxv=%b rxd=%h fe=%b done=%b busy=%b, required all 0",
               uartWr, uartRd, uartAddr, uartDatOut, txReady, rxValid, rxData, rxFerr, cfgDone, busy);
    end
    push_cfg();
    rstN = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 5) begin
        compared++;
        if (cfgDone !== 1'b0) begin
          mismatched++;
          $display("[TB] FAIL cfg_done_early: got %b at cycle 5, required 0", cfgDone);
        end
      end
    end
    compared++;
    if (cfgDone !== 1'b1 || busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL cfg_done_cycle6: got done=%b busy=%b, required done=1 busy=0", cfgDone, busy);
    end
    compared++;
    if (expQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL cfg_writes_missing: %0d pending, required 0", expQ.size());
    end
  endtask

  task automatic test_tx_round_robin();
    bit done;
    int base;
    $display("[TB] test_tx_round_robin");
    base     = wrCycles.size();
    stubUdre = 1'b1;
    txData   = 32'h003C_00A5;
    expQ.push_back(mkOp(1'b1, A_UDR, 8'hA5, 4'b0001));
    expQ.push_back(mkOp(1'b1, A_UDR, 8'h3C, 4'b0100));
    txValid  = 4'b0101;
    serve_tx(40, done);
    compared++;
    if (!done) begin
      mismatched++;
      $display("[TB] FAIL tx_rr_timeout: valid=%b pending=%0d, required both served", txValid, expQ.size());
    end
    compared++;
    if (wrCycles.size() < base + 2) begin
      mismatched++;
      $display("[TB] FAIL tx_rr_writes: got %0d UDR writes, required 2", wrCycles.size() - base);
    end else if (wrCycles[base+1] - wrCycles[base] != 3) begin
      mismatched++;
      $display("[TB] FAIL tx_rr_spacing: got %0d cycles, required 3", wrCycles[base+1] - wrCycles[base]);
    end
  endtask

  task automatic test_rx_hold();
    bit seen;
    $display("[TB] test_rx_hold");
    rxReady    = 1'b0;
    stubRxByte = 8'h55;
    stubFe     = 1'b0;
    expQ.push_back(mkOp(1'b0, A_UDR, 8'h00, 4'h0));
    rxSetCount++;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (rxValid) seen = 1'b1;
    end
    compared++;
    if (!seen || rxData !== 8'h55 || rxFerr !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL rx_first: got valid=%b data=%h fe=%b, required 1/55/0", rxValid, rxData, rxFerr);
    end
    // Second byte arrives while the holding register is full
    @(negedge clk);
    stubRxByte = 8'hE7;
    stubFe     = 1'b1;
    expQ.push_back(mkOp(1'b0, A_UDR, 8'h00, 4'h0));
    rxSetCount++;
    repeat (10) @(negedge clk);
    compared++;
    if (rxValid !== 1'b1 || rxData !== 8'h55 || rxReadCount != rxSetCount - 1) begin
      mismatched++;
      $display("[TB] FAIL rx_hold_full: got valid=%b data=%h reads=%0d, required 1/55/%0d",
               rxValid, rxData, rxReadCount, rxSetCount - 1);
    end
    rxReady = 1'b1;
    seen    = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (rxValid && rxData == 8'hE7) begin
        seen    = 1'b1;
        rxReady = 1'b0;
      end
    end
    compared++;
    if (!seen || rxFerr !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL rx_second: got valid=%b data=%h fe=%b, required 1/e7/1", rxValid, rxData, rxFerr);
    end
    rxReady = 1'b1;
    @(negedge clk);
    rxReady = 1'b0;
    compared++;
    if (rxValid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL rx_consume: got valid=%b, required 0", rxValid);
    end
    stubFe = 1'b0;
  endtask

  task automatic test_rx_before_tx();
    bit done;
    $display("[TB] test_rx_before_tx");
    rxReady    = 1'b1;
    stubRxByte = 8'h5A;
    stubFe     = 1'b0;
    stubUdre   = 1'b1;
    txData     = 32'h0000_C300;
    expQ.push_back(mkOp(1'b0, A_UDR, 8'h00, 4'h0));
    expQ.push_back(mkOp(1'b1, A_UDR, 8'hC3, 4'b0010));
    rxSetCount++;
    txValid    = 4'b0010;
    serve_tx(40, done);
    compared++;
    if (!done || rxData !== 8'h5A) begin
      mismatched++;
      $display("[TB] FAIL rx_before_tx: done=%b rxData=%h pending=%0d, required 1/5a/0",
               done, rxData, expQ.size());
    end
    rxReady = 1'b0;
  endtask

  task automatic test_cfg_during_write();
    bit sawReady;
    bit sawDoneLow;
    bit done;
    $display("[TB] test_cfg_during_write");
    txData = 32'h9900_0011;
    expQ.push_back(mkOp(1'b1, A_UDR, 8'h99, 4'b1000));
    push_cfg();
    expQ.push_back(mkOp(1'b1, A_UDR, 8'h11, 4'b0001));
    txValid  = 4'b1001;
    sawReady = 1'b0;
    for (int c = 0; c < 20 && !sawReady; c++) begin
      @(negedge clk);
      if (txReady != 4'h0) begin
        sawReady = 1'b1;
        cfgReq   = 1'b1;
      end
    end
    compared++;
    if (!sawReady) begin
      mismatched++;
      $display("[TB] FAIL cfg_wr_ready_timeout: got ready=%b, required a grant", txReady);
    end
    @(negedge clk);
    cfgReq     = 1'b0;
    txValid[3] = 1'b0;
    sawDoneLow = 1'b0;
    for (int c = 0; c < 10 && !sawDoneLow; c++) begin
      @(negedge clk);
      if (!cfgDone) sawDoneLow = 1'b1;
    end
    compared++;
    if (!sawDoneLow) begin
      mismatched++;
      $display("[TB] FAIL cfg_rerun: cfg_done stayed %b, required 0 during reconfiguration", cfgDone);
    end
    serve_tx(60, done);
    compared++;
    if (!done || cfgDone !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL cfg_after_rerun: done=%b cfg_done=%b pending=%0d, required 1/1/0",
               done, cfgDone, expQ.size());
    end
  endtask

  task automatic test_reset_mid_cfg();
    bit seenC;
    bit seenDone;
    $display("[TB] test_reset_mid_cfg");
    expQ.push_back(mkOp(1'b1, A_UBRRL, 8'h67, 4'h0));
    expQ.push_back(mkOp(1'b1, A_UBRRH, 8'h00, 4'h0));
    expQ.push_back(mkOp(1'b1, A_UCSRC, 8'h06, 4'h0));
    @(negedge clk);
    cfgReq = 1'b1;
    @(negedge clk);
    cfgReq = 1'b0;
    seenC  = 1'b0;
    for (int c = 0; c < 20 && !seenC; c++) begin
      @(negedge clk);
      if (uartWr && uartAddr == A_UCSRC) begin
        seenC = 1'b1;
        rstN  = 1'b0;
      end
    end
    compared++;
    if (!seenC) begin
      mismatched++;
      $display("[TB] FAIL mid_cfg_timeout: UCSRC write not seen, required one");
    end
    @(negedge clk);
    compared++;
    if ({uartWr, uartRd, uartAddr, uartDatOut, txReady} !== '0) begin
      mismatched++;
      $display("[TB] FAIL mid_cfg_reset_bus: got wr=%b rd=%b addr=%h dat=%h ready=%b, required all 0",
               uartWr, uartRd, uartAddr, uartDatOut, txReady);
    end
    push_cfg();
    rstN     = 1'b1;
    seenDone = 1'b0;
    for (int c = 0; c < 20 && !seenDone; c++) begin
      @(negedge clk);
      if (cfgDone) seenDone = 1'b1;
    end
    compared++;
    if (!seenDone || expQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL mid_cfg_restart: cfg_done=%b pending=%0d, required 1/0", cfgDone, expQ.size());
    end
  endtask

  initial begin
    rstN        = 1'b0;
    cfgReq      = 1'b0;
    txValid     = 4'h0;
    txData      = 32'h0;
    rxReady     = 1'b0;
    stubUdre    = 1'b0;
    stubFe      = 1'b0;
    stubRxByte  = 8'h00;
    rxSetCount  = 0;
    rxReadCount = 0;
    cycleCount  = 0;
    compared    = 0;
    mismatched  = 0;
    fork
      run_bus_monitor();
    join_none
    test_reset();
    test_tx_round_robin();
    test_rx_hold();
    test_rx_before_tx();
    test_cfg_during_write();
    test_reset_mid_cfg();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
